// File: rtl/hitmem_slot_arbiter_pkg.sv
// Shared types and constants for the hit-memory slot arbiter: FSM encoding and default geometry.
package hitmem_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned NSLOT_DEF = 32;
  localparam int unsigned AW_DEF    = $clog2(NSLOT_DEF);
  localparam int unsigned SW_DEF    = $clog2(NREQ_DEF);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

endpackage

// File: rtl/hitmem_slot_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr_i, cyclic.
module hitmem_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned SW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [SW-1:0]   rr_ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [SW-1:0]   win_o,
  output logic            any_o
);

  logic [SW-1:0] idx;
  logic          found;

  always_comb begin
    gnt_o = '0;
    win_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = SW'((32'(rr_ptr_i) + i) % NREQ);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win_o = idx;
      end
    end
    if (found) gnt_o[win_o] = 1'b1;
    any_o = found;
  end

endmodule

// File: rtl/hitmem_slot_arbiter.sv
// Hit-memory slot arbiter: round-robin hit writes (FILL), address readout (DRAIN), pool recycle (CLEAR).
// Optional dropped-hit statistics port enabled by HITMEM_ARB_STATS_EN.
module hitmem_slot_arbiter
  import hitmem_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned NSLOT = NSLOT_DEF,
  localparam int unsigned AW   = $clog2(NSLOT),
  localparam int unsigned SW   = $clog2(NREQ)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            wr_en_o,
  output logic [AW-1:0]   wr_addr_o,
  output logic [SW-1:0]   wr_src_o,
  input  logic            ev_end_i,
  output logic            rd_valid_o,
  input  logic            rd_ready_i,
  output logic [AW-1:0]   rd_addr_o,
  output logic            rd_last_o,
  output logic [AW:0]     count_o,
  output logic            full_o,
  output logic            overflow_o,
  output logic            busy_o
`ifdef HITMEM_ARB_STATS_EN
  ,
  output logic [15:0]     drop_cnt_o
`endif
);

  state_e          state_q;
  logic [SW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [AW-1:0]   rd_addr_q;
  logic            ovf_q, busy_q;

  logic            in_fill, in_drain, full_c;
  logic [NREQ-1:0] req_fill, pick_gnt;
  logic [SW-1:0]   pick_win;
  logic            pick_any, hit_drop;
  logic            rd_valid_c, rd_last_c, rd_fire;

  assign in_fill  = (state_q == ST_FILL);
  assign in_drain = (state_q == ST_DRAIN);
  assign full_c   = (count_q == (AW+1)'(NSLOT));

  // Requests only compete while the pool is accepting hits.
  assign req_fill = in_fill ? req_i : '0;

  hitmem_rr_pick #(
    .NREQ (NREQ),
    .SW   (SW)
  ) u_pick (
    .req_i    (req_fill),
    .rr_ptr_i (rr_ptr_q),
    .gnt_o    (pick_gnt),
    .win_o    (pick_win),
    .any_o    (pick_any)
  );

  assign hit_drop = pick_any & full_c;
  assign rr_ptr_d = (pick_win == SW'(NREQ - 1)) ? '0 : pick_win + SW'(1);
  assign count_d  = (pick_any && !full_c) ? count_q + (AW+1)'(1) : count_q;

  assign rd_valid_c = in_drain && (count_q != '0);
  assign rd_last_c  = rd_valid_c && (rd_addr_q == AW'(count_q - (AW+1)'(1)));
  assign rd_fire    = rd_valid_c & rd_ready_i;

  assign gnt_o      = pick_gnt;
  assign wr_en_o    = pick_any & ~full_c;
  assign wr_addr_o  = count_q[AW-1:0];
  assign wr_src_o   = pick_win;
  assign rd_valid_o = rd_valid_c;
  assign rd_addr_o  = rd_addr_q;
  assign rd_last_o  = rd_last_c;
  assign count_o    = count_q;
  assign full_o     = full_c;
  assign overflow_o = ovf_q;
  assign busy_o     = busy_q;

  // Event sequencer, slot counter and readout address generator.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_FILL;
      rr_ptr_q  <= '0;
      count_q   <= '0;
      rd_addr_q <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (pick_any) rr_ptr_q <= rr_ptr_d;
          count_q <= count_d;
          if (hit_drop) ovf_q <= 1'b1;
          if (ev_end_i) begin
            state_q   <= ST_DRAIN;
            busy_q    <= 1'b1;
            rd_addr_q <= '0;
          end
        end
        ST_DRAIN: begin
          if (count_q == '0) begin
            state_q <= ST_CLEAR;
          end else if (rd_fire) begin
            if (rd_last_c) begin
              state_q   <= ST_CLEAR;
              rd_addr_q <= '0;
            end else begin
              rd_addr_q <= rd_addr_q + AW'(1);
            end
          end
        end
        ST_CLEAR: begin
          count_q <= '0;
          ovf_q   <= 1'b0;
          state_q <= ST_FILL;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= ST_FILL;
          busy_q    <= 1'b0;
          rd_addr_q <= '0;
        end
      endcase
    end
  end

`ifdef HITMEM_ARB_STATS_EN
  logic [15:0] drop_cnt_q;

  // Saturating count of discarded hits; survives event boundaries.
  always_ff @(posedge clock) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else if (in_fill && hit_drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_hitmem_slot_arbiter.sv
// Scoreboard bench for hitmem_slot_arbiter (NREQ=4, NSLOT=32): queue-based behavioural model vs DUT.
module tb_hitmem_slot_arbiter;

  localparam int PH_FILL  = 0;
  localparam int PH_DRAIN = 1;
  localparam int PH_CLEAR = 2;

  logic       clock;
  logic       reset;
  logic [3:0] req_i;
  logic [3:0] gnt_o;
  logic       wr_en_o;
  logic [4:0] wr_addr_o;
  logic [1:0] wr_src_o;
  logic       ev_end_i;
  logic       rd_valid_o;
  logic       rd_ready_i;
  logic [4:0] rd_addr_o;
  logic       rd_last_o;
  logic [5:0] count_o;
  logic       full_o;
  logic       overflow_o;
  logic       busy_o;
`ifdef HITMEM_ARB_STATS_EN
  logic [15:0] drop_cnt_o;
`endif

  hitmem_slot_arbiter #(.NREQ(4), .NSLOT(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_i      (req_i),
    .gnt_o      (gnt_o),
    .wr_en_o    (wr_en_o),
    .wr_addr_o  (wr_addr_o),
    .wr_src_o   (wr_src_o),
    .ev_end_i   (ev_end_i),
    .rd_valid_o (rd_valid_o),
    .rd_ready_i (rd_ready_i),
    .rd_addr_o  (rd_addr_o),
    .rd_last_o  (rd_last_o),
    .count_o    (count_o),
    .full_o     (full_o),
    .overflow_o (overflow_o),
    .busy_o     (busy_o)
`ifdef HITMEM_ARB_STATS_EN
    ,
    .drop_cnt_o (drop_cnt_o)
`endif
  );

  typedef struct packed {
    logic [3:0]  gnt;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [1:0]  wr_src;
    logic        rd_valid;
    logic [4:0]  rd_addr;
    logic        rd_last;
    logic [5:0]  count;
    logic        full;
    logic        ovf;
    logic        busy;
    logic [15:0] drop;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model: the event's hits as a list of source channels, plus readout position.
  int   m_phase;
  int   m_rr;
  int   m_hits[$];
  bit   m_ovf;
  int   m_drop;
  int   m_pos;
  logic [3:0] pending;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("gnt", 32'(gnt_o), 32'(e.gnt));
      check("wr_en", 32'(wr_en_o), 32'(e.wr_en));
      if (e.gnt != 4'd0) check("wr_src", 32'(wr_src_o), 32'(e.wr_src));
      if (e.wr_en) check("wr_addr", 32'(wr_addr_o), 32'(e.wr_addr));
      check("rd_valid", 32'(rd_valid_o), 32'(e.rd_valid));
      check("rd_last", 32'(rd_last_o), 32'(e.rd_last));
      if (e.rd_valid) check("rd_addr", 32'(rd_addr_o), 32'(e.rd_addr));
      check("count", 32'(count_o), 32'(e.count));
      check("full", 32'(full_o), 32'(e.full));
      check("overflow", 32'(overflow_o), 32'(e.ovf));
      check("busy", 32'(busy_o), 32'(e.busy));
`ifdef HITMEM_ARB_STATS_EN
      check("drop_cnt", 32'(drop_cnt_o), 32'(e.drop));
`endif
    end
  end

  task automatic model_reset();
    m_phase = PH_FILL;
    m_rr    = 0;
    m_hits.delete();
    m_ovf   = 1'b0;
    m_drop  = 0;
    m_pos   = 0;
  endtask

  // Drive one cycle, push its expected outputs, advance the model across the next edge.
  task automatic step(input bit ev, input bit rdy, input bit rst);
    exp_t e;
    int   cnt;
    int   w;
    req_i      = pending;
    ev_end_i   = ev;
    rd_ready_i = rdy;
    reset      = rst;
    e          = '0;
    cnt        = m_hits.size();
    w          = -1;
    e.count    = 6'(cnt);
    e.full     = (cnt == 32);
    e.ovf      = m_ovf;
    e.busy     = (m_phase != PH_FILL);
    e.drop     = 16'(m_drop);
    if (m_phase == PH_FILL) begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_rr + k) % 4;
        if (w < 0 && pending[c]) w = c;
      end
      if (w >= 0) begin
        e.gnt    = 4'(1 << w);
        e.wr_src = 2'(w);
        if (cnt < 32) begin
          e.wr_en   = 1'b1;
          e.wr_addr = 5'(cnt);
        end
      end
    end
    if (m_phase == PH_DRAIN && cnt > 0) begin
      e.rd_valid = 1'b1;
      e.rd_addr  = 5'(m_pos);
      e.rd_last  = (m_pos == cnt - 1);
    end
    exp_q.push_back(e);
    if (w >= 0) pending[w] = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      case (m_phase)
        PH_FILL: begin
          if (w >= 0) begin
            m_rr = (w + 1) % 4;
            if (cnt < 32) m_hits.push_back(w);
            else begin
              m_ovf = 1'b1;
              if (m_drop < 65535) m_drop++;
            end
          end
          if (ev) begin
            m_phase = PH_DRAIN;
            m_pos   = 0;
          end
        end
        PH_DRAIN: begin
          if (cnt == 0) m_phase = PH_CLEAR;
          else if (rdy) begin
            if (m_pos == cnt - 1) m_phase = PH_CLEAR;
            else m_pos++;
          end
        end
        default: begin
          m_hits.delete();
          m_ovf   = 1'b0;
          m_phase = PH_FILL;
        end
      endcase
    end
    @(posedge clock);
    #1;
  endtask

  task automatic fill_singles(input int target);
    for (int i = 0; i < 200 && m_hits.size() < target; i++) begin
      if (pending == 4'd0) pending = 4'(1 << $urandom_range(0, 3));
      step(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic drain_out(input logic [3:0] pat);
    for (int k = 0; k < 200 && m_phase != PH_FILL; k++) step(1'b0, pat[k % 4], 1'b0);
  endtask

  initial begin
    logic [3:0] pat;
    reset      = 1'b1;
    req_i      = '0;
    ev_end_i   = 1'b0;
    rd_ready_i = 1'b0;
    pending    = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    step(1'b0, 1'b0, 1'b0);

    // Three channels requesting from rr_ptr=0.
    pending = 4'b1011;
    repeat (4) step(1'b0, 1'b0, 1'b0);

    // Fill the pool, then three discarded hits from channel 2.
    fill_singles(32);
    for (int i = 0; i < 3; i++) begin
      pending[2] = 1'b1;
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    drain_out(4'b1111);

    // ev_end coinciding with a grant at count=5; stalled readout.
    fill_singles(5);
    pending = 4'b0010;
    step(1'b1, 1'b0, 1'b0);
    pat = 4'b1001;
    drain_out(pat);
    step(1'b0, 1'b0, 1'b0);

    // Empty event.
    step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Reset while draining at rd_addr=7.
    fill_singles(12);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 50 && m_pos != 7; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Randomized traffic, events and back-pressure.
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < 4; c++)
        if (!pending[c] && $urandom_range(0, 99) < 35) pending[c] = 1'b1;
      step($urandom_range(0, 29) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 399) == 0);
    end

    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
